// File: rtl/lsu_pkg.sv
// lsu_pkg: memop encodings and FSM state type shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_D  = 3'b011;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;
  localparam logic [2:0] MOP_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: misalign/opcode check, store lane shift and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic        store,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic        err,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);
  logic [1:0]  sz;
  logic        sx;
  logic [63:0] rd_sh;
  always_comb begin
    sz = memop[1:0];
    sx = ~memop[2];
    rd_sh = rdata >> {off, 3'b000};
    err = (store ? memop[2] : memop == 3'b111) |
          (sz == MOP_H[1:0] ? off[0] : sz == MOP_W[1:0] ? |off[1:0] : sz == MOP_D[1:0] ? |off : 1'b0);
    wmask = (sz == MOP_B[1:0] ? 8'h01 : sz == MOP_H[1:0] ? 8'h03 : sz == MOP_W[1:0] ? 8'h0f : 8'hff) << off;
    wdata_sh = wdata << {off, 3'b000};
    rdata_ext = sz == MOP_B[1:0] ? {{56{sx & rd_sh[7]}}, rd_sh[7:0]} :
                sz == MOP_H[1:0] ? {{48{sx & rd_sh[15]}}, rd_sh[15:0]} :
                sz == MOP_W[1:0] ? {{32{sx & rd_sh[31]}}, rd_sh[31:0]} : rd_sh;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: multi-cycle M-stage load/store unit on a valid/ready memory bus
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_memop,
  input  logic [ADDR_W-1:0] in_alures,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);
  state_t            state, state_nx;
  logic [2:0]        memop_q, off_q;
  logic              store_q, is_mem, idle;
  logic              a_err;
  logic [7:0]        a_wmask;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  assign idle = state == IDLE;
  assign is_mem = in_load | in_store;
  // the aligner sees the incoming entry while idle and the latched one afterwards
  lsu_align u_align (
    .memop     (idle ? in_memop : memop_q),
    .store     (idle ? in_store : store_q),
    .off       (idle ? in_alures[2:0] : off_q),
    .wdata     (in_wdata),
    .rdata     (mem_resp_rdata),
    .err       (a_err),
    .wmask     (a_wmask),
    .wdata_sh  (a_wdata),
    .rdata_ext (a_rdata)
  );
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? (is_mem && !a_err ? REQ : DONE) : IDLE;
      REQ:     state_nx = mem_req_ready ? WAIT : REQ;
      WAIT:    state_nx = mem_resp_valid ? DONE : WAIT;
      default: state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    mem_req_valid = state == REQ;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      out_data <= '0;
      out_err <= 1'b0;
      mem_req_wen <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      memop_q <= '0;
      off_q <= '0;
      store_q <= 1'b0;
    end else if (idle && in_valid) begin
      out_data <= is_mem ? '0 : DATA_W'(in_alures);
      out_err <= is_mem & a_err;
      mem_req_wen <= in_store;
      mem_req_addr <= {in_alures[ADDR_W-1:3], 3'b000};
      mem_req_wdata <= in_store ? a_wdata : '0;
      mem_req_wmask <= in_store ? a_wmask : '0;
      memop_q <= in_memop;
      off_q <= in_alures[2:0];
      store_q <= in_store;
    end else if (state == WAIT && mem_resp_valid) begin
      out_data <= store_q ? '0 : a_rdata;
    end
endmodule
